// File: rtl/uart_rx_frame.sv
// UART receive framer: 3-tap majority oversampling, optional parity, one stop bit.
// Good frames update P_DATA with a one-cycle data_valid; bad frames pulse par_err/stp_err.
module uart_rx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      tap0_q, tap0_d;
    logic                      tap1_q, tap1_d;
    logic                      par_flag_q, par_flag_d;
    logic                      stp_flag_q, stp_flag_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      at_tap0, at_tap1, at_res, at_end, maj;

    always_comb begin
        half    = prescale_q >> 1;
        at_tap0 = (edge_cnt_q == half - PRESCALE_WIDTH'(1));
        at_tap1 = (edge_cnt_q == half);
        at_res  = (edge_cnt_q == half + PRESCALE_WIDTH'(1));
        at_end  = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));
        maj     = (tap0_q & tap1_q) | (tap0_q & RX_IN) | (tap1_q & RX_IN);

        state_d      = state_q;
        edge_cnt_d   = at_end ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        prescale_d   = prescale_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        tap0_d       = at_tap0 ? RX_IN : tap0_q;
        tap1_d       = at_tap1 ? RX_IN : tap1_q;
        par_flag_d   = par_flag_q;
        stp_flag_d   = stp_flag_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            // DONE doubles as an idle cycle so a start edge landing on it is not lost
            IDLE, DONE: begin
                edge_cnt_d = '0;
                state_d    = IDLE;
                if (!RX_IN) begin
                    state_d    = START;
                    edge_cnt_d = PRESCALE_WIDTH'(1);
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    bit_cnt_d  = '0;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end
            end
            START: begin
                if (at_res && maj) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (at_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (at_res) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (at_res) par_flag_d = maj ^ (^shift_q) ^ par_typ_q;
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_res) stp_flag_d = ~maj;
                if (at_end) begin
                    state_d      = DONE;
                    data_valid_d = ~par_flag_q & ~stp_flag_q;
                    par_err_d    = par_flag_q;
                    stp_err_d    = stp_flag_q;
                    if (~par_flag_q & ~stp_flag_q) p_data_d = shift_q;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            prescale_q   <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_q      <= '0;
            tap0_q       <= 1'b1;
            tap1_q       <= 1'b1;
            par_flag_q   <= 1'b0;
            stp_flag_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            prescale_q   <= prescale_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            tap0_q       <= tap0_d;
            tap1_q       <= tap1_d;
            par_flag_q   <= par_flag_d;
            stp_flag_q   <= stp_flag_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and random serial frames against a frame-level
// reference model that predicts each frame's outcome and its completion cycle.
module tb_uart_rx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned cyc;
        logic        dv, pe, se;
        logic [7:0]  pd;
    } exp_t;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t        exp_q[$];
    logic [7:0]  model_good = '0;
    logic [7:0]  ref_pdata = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int rand_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Outputs are compared mid-cycle against the predicted event for this cycle.
    always @(negedge CLK) begin
        if (RST) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_valid", 32'(data_valid), 32'(e.dv));
                check("par_err", 32'(par_err), 32'(e.pe));
                check("stp_err", 32'(stp_err), 32'(e.se));
                check("p_data", 32'(P_DATA), 32'(e.pd));
                ref_pdata = e.pd;
            end else if (data_valid || par_err || stp_err) begin
                check("spurious_pulse", 32'({data_valid, par_err, stp_err}), 0);
            end
            if (P_DATA !== ref_pdata) check("p_data_hold", 32'(P_DATA), 32'(ref_pdata));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            RX_IN = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                              input bit bad_par, input bit stop_v, input int noise_bit,
                              input int noise_off, input int abort_at);
        int   n;
        logic bits[11];
        logic v;
        exp_t e;
        n = pe ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe) bits[9] = (^d) ^ pt ^ bad_par;
        bits[n-1] = stop_v;
        for (int c = 0; c < n * p; c++) begin
            @(posedge CLK); #1;
            if (c == abort_at) begin
                RST = 1'b0;
                RX_IN = 1'b1;
                exp_q.delete();
                model_good = '0;
                ref_pdata = '0;
                @(negedge CLK);
                check("rst_p_data", 32'(P_DATA), 0);
                check("rst_pulses", 32'({data_valid, par_err, stp_err}), 0);
                @(posedge CLK); #1;
                RST = 1'b1;
                return;
            end
            v = bits[c / p];
            if (noise_bit >= 0 && c == (noise_bit + 1) * p + p / 2 + noise_off) v = ~v;
            RX_IN = v;
            if (c == 0) begin
                Prescale = 6'(p);
                PAR_EN = pe;
                PAR_TYP = pt;
                e.cyc = cyc + n * p;
                e.se = ~stop_v;
                e.pe = pe & bad_par;
                e.dv = ~e.se & ~e.pe;
                if (e.dv) model_good = d;
                e.pd = model_good;
                exp_q.push_back(e);
            end else if (c == 1) begin
                // configuration is latched at the start edge; scramble it mid-frame
                Prescale = 6'(rand_p());
                PAR_EN = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_p_data", 32'(P_DATA), 0);
        check("reset_data_valid", 32'(data_valid), 0);
        check("reset_par_err", 32'(par_err), 0);
        check("reset_stp_err", 32'(stp_err), 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        idle(5);

        send_frame(8'hA5, 8, 0, 0, 0, 1, -1, 0, -1);
        idle(3);
        send_frame(8'h3C, 16, 1, 0, 0, 1, -1, 0, -1);
        idle(3);
        send_frame(8'h3C, 16, 1, 0, 1, 1, -1, 0, -1);
        idle(3);
        send_frame(8'h5A, 32, 0, 0, 0, 0, -1, 0, -1);
        idle(3);

        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            RX_IN = 1'b0;
        end
        idle(40);

        send_frame(8'h01, 8, 0, 0, 0, 1, -1, 0, -1);
        send_frame(8'hFE, 8, 0, 0, 0, 1, -1, 0, -1);
        idle(3);
        send_frame(8'h08, 8, 0, 0, 0, 1, 3, 0, -1);
        idle(3);
        send_frame(8'h77, 8, 0, 0, 0, 1, -1, 0, 40);
        idle(3);
        send_frame(8'hC3, 8, 1, 1, 0, 1, -1, 0, -1);
        idle(3);
        send_frame(8'h99, 8, 0, 0, 0, 0, -1, 0, -1);
        send_frame(8'h42, 8, 0, 0, 0, 1, -1, 0, -1);
        idle(3);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            int         nb;
            d = 8'($urandom);
            nb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            send_frame(d, rand_p(), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0,
                       nb, int'($urandom_range(0, 2)) - 1, -1);
            idle(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1);
        idle(2);
        check("drain", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive front-end of the UART path. Oversamples `RX_IN` with the UART-domain clock and recovers 8-bit frames: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit. Good frames are presented as a parallel word plus a one-cycle valid flag. Its `P_DATA`/`data_valid` pair is the unsynchronised bus/enable pair that the reference-domain data synchroniser samples, so `P_DATA` must stay stable between valid pulses.

## Interface

Parameters:
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_WIDTH`, 6: width of the `Prescale` input.

Ports:
- `CLK` input 1: UART RX oversampling clock. All logic is on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line. Idle high. Pre-synchronised to `CLK` upstream.
- `Prescale` input PRESCALE_WIDTH: oversampling ratio P. Legal values are 8, 16 and 32; other values are unsupported.
- `PAR_EN` input 1: 1 = the frame carries a parity bit.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `P_DATA` output DATA_WIDTH: last good payload.
- `data_valid` output 1: one-cycle pulse for each good frame.
- `par_err` output 1: one-cycle pulse when a frame has a parity error.
- `stp_err` output 1: one-cycle pulse when a frame has a stop-bit error.

## Operation

- **FSM states:** IDLE, START, DATA, PARITY, STOP, DONE.
- **Counters:**
  - `edge_cnt` runs 0..P-1 within each bit.
  - `bit_cnt` runs 0..DATA_WIDTH-1 in DATA.
- **Per-frame latch:** `Prescale`, `PAR_EN` and `PAR_TYP` are latched on the IDLE→START transition. Changing them mid-frame does not affect the current frame.
- **Sampling:** each bit value is the 2-of-3 majority of `RX_IN` at edge_cnt = P/2-1, P/2 and P/2+1. The value is resolved at edge_cnt = P/2+1.
- **IDLE:**
  - `RX_IN`=0 → START. The cycle `RX_IN` is first seen low is edge 0 of the start bit (frame cycle 0).
- **START:**
  - Majority sample = 1 → glitch; return to IDLE at edge_cnt = P/2+1. No outputs change.
  - Otherwise go to DATA at edge_cnt = P-1.
- **DATA:**
  - Samples shift into an internal shift register, LSB first.
  - After bit DATA_WIDTH-1 ends, go to PARITY if the latched `PAR_EN`=1, else STOP.
- **PARITY:**
  - Expected bit = XOR of the data bits, XOR the latched `PAR_TYP`.
  - A mismatch sets an internal parity flag.
- **STOP:**
  - Sample = 0 sets an internal stop flag.
  - At edge_cnt = P-1 go to DONE.
- **DONE (one cycle):**
  - No flags set: `data_valid`=1 and `P_DATA` ← shift register.
  - Otherwise `data_valid`=0, `P_DATA` is held, and `par_err`/`stp_err` pulse according to their flags. Both may pulse together.
  - Next state is START if `RX_IN`=0 this cycle (back-to-back frame; this cycle is edge 0), else IDLE.
- **Reset values:** `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0. FSM goes to IDLE and all counters and flags clear.
- **Reset mid-frame:** the frame is discarded and no pulse is produced.
- **`P_DATA` stability:** `P_DATA` changes only in the cycle `data_valid` is high. Between valid pulses it is held for at least one full frame, which satisfies the downstream synchroniser's bus stability rule.
- **Counter widths:** `edge_cnt` is PRESCALE_WIDTH bits. `bit_cnt` is clog2(DATA_WIDTH) bits. Neither counter wraps outside its state.

## Timing

- Frame length N = 10 bits without parity, 11 with parity.
- The outputs (`data_valid`, or `par_err`/`stp_err`) are high in cycle N·P, counted from frame cycle 0. They are registered and high for exactly one cycle.
  - P=8, no parity: valid at cycle 80.
  - P=16, parity: valid at cycle 176.
- Data bit k is resolved at cycle (k+1)·P + P/2 + 1.
- **Back-to-back frames:** the next start edge may coincide with the DONE cycle. A stop bit exactly P cycles long followed immediately by a start bit is received without loss.
- **Line held low:** a frame whose stop bit is 0 gives `stp_err`. If `RX_IN` is still low in DONE, a new frame starts immediately. No deadlock.
- **Single-cycle noise:** one wrong sample out of the 3 majority taps does not change the bit.

## Test plan

- **Basic frame:** P=8, `PAR_EN`=0, frame 0xA5 → `data_valid`=1 at cycle 80, `P_DATA`=0xA5, no error pulses.
- **Parity:**
  - P=16, even parity, 0x3C with parity bit 0 → valid at cycle 176.
  - Same frame with parity bit 1 → `par_err` at cycle 176, `P_DATA` keeps its previous value.
- **Stop error and start glitch:**
  - P=32, stop bit driven 0 → `stp_err` pulse at cycle 320 and no `data_valid`.
  - `RX_IN` low for 3 cycles only → FSM returns to IDLE and no outputs change.
- **Back-to-back frames:** P=8, frames 0x01 then 0xFE with no idle gap → `data_valid` at cycles 80 and 160, with `P_DATA` 0x01 then 0xFE.
- **Noise and reset:**
  - One-cycle inversion at the P/2 tap of data bit 3 → value unaffected.
  - `RST` asserted at cycle 40 of a frame → all outputs 0, FSM in IDLE, the next full frame is received correctly.
